// File: rtl/multicycle_alu.sv
// Execute-stage ALU: registered single-cycle ops plus iterative unsigned MULTU/DIVU
// behind a start/done handshake, with a HI word for the wide results.
module multicycle_alu #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic [WIDTH-1:0]   Hi,
  output logic               Zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MULTU = 4'b0101;
  localparam logic [3:0] OP_DIVU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_MEM   = 4'b1010;
  localparam logic [3:0] OP_JR    = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1110;

  localparam logic [WIDTH-1:0]   MEM_BASE  = WIDTH'(32'h1001_0000);
  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic               mul_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [SHAMT_W-1:0] cnt_r;

  logic               multi_op_s;
  logic [WIDTH-1:0]   single_res_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_sh_s;
  logic [WIDTH+1:0]   div_tr_s;
  logic [WIDTH-1:0]   hi_nxt_s;
  logic [WIDTH-1:0]   lo_nxt_s;

  assign multi_op_s = (ALUOperation == OP_MULTU) || (ALUOperation == OP_DIVU);

  // acc_hi holds the partial product / running remainder, acc_lo the multiplier / quotient.
  assign mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
  assign div_sh_s  = {acc_hi_r, acc_lo_r[WIDTH-1]};
  // Two guard bits so a zero divisor never looks like a borrow, leaving all-ones / A.
  assign div_tr_s  = {1'b0, div_sh_s} - {2'b00, b_r};

  // Single-cycle result, evaluated on the live operands at accept time.
  always_comb begin
    single_res_s = {WIDTH{1'b0}};
    case (ALUOperation)
      OP_AND:  single_res_s = A & B;
      OP_OR:   single_res_s = A | B;
      OP_NOR:  single_res_s = ~(A | B);
      OP_ADD:  single_res_s = A + B;
      OP_SUB:  single_res_s = A - B;
      OP_SLL:  single_res_s = B << Shamt;
      OP_SRL:  single_res_s = B >> Shamt;
      OP_MEM:  single_res_s = (A + B - MEM_BASE) >> 2'd2;
      OP_JR:   single_res_s = A;
      OP_BEQ:  single_res_s = A - B;
      OP_LUI:  single_res_s = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: single_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add or restoring shift-subtract step.
  always_comb begin
    hi_nxt_s = acc_hi_r;
    lo_nxt_s = acc_lo_r;
    if (mul_r) begin
      hi_nxt_s = mul_sum_s[WIDTH:1];
      lo_nxt_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    end else if (!div_tr_s[WIDTH+1]) begin
      hi_nxt_s = div_tr_s[WIDTH-1:0];
      lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt_s = div_sh_s[WIDTH-1:0];
      lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ALUResult <= {WIDTH{1'b0}};
      Hi        <= {WIDTH{1'b0}};
      Zero      <= 1'b1;
      mul_r     <= 1'b0;
      b_r       <= {WIDTH{1'b0}};
      acc_hi_r  <= {WIDTH{1'b0}};
      acc_lo_r  <= {WIDTH{1'b0}};
      cnt_r     <= {SHAMT_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (multi_op_s) begin
              state_r  <= S_RUN;
              busy     <= 1'b1;
              cnt_r    <= {SHAMT_W{1'b0}};
              mul_r    <= (ALUOperation == OP_MULTU);
              b_r      <= B;
              acc_hi_r <= {WIDTH{1'b0}};
              acc_lo_r <= A;
            end else begin
              state_r   <= S_DONE;
              done      <= 1'b1;
              ALUResult <= single_res_s;
              Hi        <= {WIDTH{1'b0}};
              Zero      <= (single_res_s == {WIDTH{1'b0}});
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_hi_r <= hi_nxt_s;
          acc_lo_r <= lo_nxt_s;
          if (cnt_r == LAST_STEP) begin
            state_r   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            ALUResult <= lo_nxt_s;
            Hi        <= hi_nxt_s;
            Zero      <= (lo_nxt_s == {WIDTH{1'b0}});
          end else begin
            cnt_r <= cnt_r + SHAMT_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: a 32-bit and a 16-bit instance, directed
// cases plus randomized ops checked against a plain-arithmetic reference model.
module tb_multicycle_alu;

  localparam int W   = 32;
  localparam int SW  = $clog2(W);
  localparam int W16 = 16;

  localparam logic [3:0] OP_AND = 4'b0000, OP_ADD = 4'b0011, OP_MULTU = 4'b0101,
                         OP_DIVU = 4'b0110, OP_SLL = 4'b1000, OP_MEM = 4'b1010,
                         OP_BEQ = 4'b1100, OP_LUI = 4'b1110;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        z;
    int          acc;
    int          lat;
    int          dut;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    ALUOperation;
  logic [W-1:0]  A, B;
  logic [SW-1:0] Shamt;
  logic          busy, done, Zero;
  logic [W-1:0]  ALUResult, Hi;

  logic          start16;
  logic [3:0]    op16;
  logic [15:0]   a16, b16;
  logic [3:0]    sh16;
  logic          busy16, done16, zero16;
  logic [15:0]   res16, hi16;

  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  logic end_req = 1'b0;
  exp_t exp_q[$];

  multicycle_alu #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .Shamt(Shamt), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Hi(Hi), .Zero(Zero)
  );

  multicycle_alu #(.WIDTH(W16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .ALUOperation(op16),
    .A(a16), .B(b16), .Shamt(sh16), .busy(busy16), .done(done16),
    .ALUResult(res16), .Hi(hi16), .Zero(zero16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: straight arithmetic on 64-bit values, reduced modulo 2^w.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     input int sh, input int w);
    exp_t e;
    logic [63:0] m, p;
    m = (64'd1 << w) - 64'd1;
    e = '0;
    case (op)
      4'b0000: e.lo = a & b;
      4'b0001: e.lo = a | b;
      4'b0010: e.lo = ~(a | b) & m;
      4'b0011: e.lo = (a + b) & m;
      4'b0100: e.lo = (a - b) & m;
      4'b0101: begin p = a * b; e.lo = p & m; e.hi = p >> w; end
      4'b0110: begin
        if (b == 64'd0) begin e.lo = m; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      4'b1000: e.lo = (b << sh) & m;
      4'b1001: e.lo = b >> sh;
      4'b1010: e.lo = ((a + b - 64'h1001_0000) & m) >> 2;
      4'b1011: e.lo = a;
      4'b1100: e.lo = (a - b) & m;
      4'b1110: e.lo = (b & ((64'd1 << (w / 2)) - 64'd1)) << (w / 2);
      default: e.lo = 64'd0;
    endcase
    e.z = (e.lo == 64'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = $urandom_range(0, 15);
      2:       v = 32'hFFFF_FFFF;
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks holding/reset/timeout otherwise.
  initial begin
    exp_t        e;
    logic [63:0] o_lo[2], o_hi[2], h_lo[2], h_hi[2];
    logic        o_busy[2], o_done[2], o_z[2], h_z[2];
    int          brun[2];
    for (int d = 0; d < 2; d++) begin
      h_lo[d] = 64'd0; h_hi[d] = 64'd0; h_z[d] = 1'b1; brun[d] = 0;
    end
    forever begin
      @(negedge clk);
      o_lo[0] = 64'(ALUResult); o_hi[0] = 64'(Hi); o_z[0] = Zero; o_busy[0] = busy; o_done[0] = done;
      o_lo[1] = 64'(res16); o_hi[1] = 64'(hi16); o_z[1] = zero16; o_busy[1] = busy16; o_done[1] = done16;
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          chk("reset busy", d, 64'(o_busy[d]), 64'd0);
          chk("reset done", d, 64'(o_done[d]), 64'd0);
          chk("reset result", d, o_lo[d], 64'd0);
          chk("reset hi", d, o_hi[d], 64'd0);
          chk("reset zero", d, 64'(o_z[d]), 64'd1);
          h_lo[d] = 64'd0; h_hi[d] = 64'd0; h_z[d] = 1'b1; brun[d] = 0;
        end else begin
          if (o_busy[d]) brun[d]++;
          if (o_done[d]) begin
            if (exp_q.size() == 0 || exp_q[0].dut != d) begin
              ncmp++; nfail++;
              $display("FAIL dut%0d spurious done: got done=1, expected no pending op (cycle %0d)", d, cyc);
            end else begin
              e = exp_q.pop_front();
              chk("result", d, o_lo[d], e.lo);
              chk("hi", d, o_hi[d], e.hi);
              chk("zero", d, 64'(o_z[d]), 64'(e.z));
              chk("latency", d, 64'(cyc - e.acc + 1), 64'(e.lat));
              chk("busy cycles", d, 64'(brun[d]), 64'(e.lat - 1));
            end
            h_lo[d] = o_lo[d]; h_hi[d] = o_hi[d]; h_z[d] = o_z[d]; brun[d] = 0;
          end else begin
            chk("hold result", d, o_lo[d], h_lo[d]);
            chk("hold hi", d, o_hi[d], h_hi[d]);
            chk("hold zero", d, 64'(o_z[d]), 64'(h_z[d]));
            if (exp_q.size() > 0 && exp_q[0].dut == d && cyc > exp_q[0].acc + exp_q[0].lat - 1) begin
              ncmp++; nfail++;
              $display("FAIL dut%0d timeout: got no done, expected done at latency %0d", d, exp_q[0].lat);
              void'(exp_q.pop_front());
            end
          end
        end
      end
      if (end_req) begin
        chk("pending ops at end", 0, 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
      end
    end
  end

  // Issue one op on the 32-bit DUT; pulses: 0 none, 1 at cycles 3 and 10, 2 random while busy.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] sh, input int pulses);
    exp_t e;
    logic multi;
    multi = (op == OP_MULTU) || (op == OP_DIVU);
    e = ref_model(op, 64'(a), 64'(b), int'(sh), W);
    ALUOperation = op; A = a; B = b; Shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    e.acc = cyc; e.lat = multi ? W + 1 : 1; e.dut = 0;
    exp_q.push_back(e);
    start = 1'b0;
    for (int k = 1; k <= W + 8; k++) begin
      @(negedge clk);
      if (done) break;
      start = (pulses == 1 && (k == 3 || k == 10)) || (pulses == 2 && $urandom_range(0, 7) == 0);
      if (start) begin
        ALUOperation = 4'($urandom); A = $urandom; B = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    exp_t e;
    logic multi;
    multi = (op == OP_MULTU) || (op == OP_DIVU);
    e = ref_model(op, 64'(a), 64'(b), int'(sh), W16);
    op16 = op; a16 = a; b16 = b; sh16 = sh; start16 = 1'b1;
    @(posedge clk); #1;
    e.acc = cyc; e.lat = multi ? W16 + 1 : 1; e.dut = 1;
    exp_q.push_back(e);
    start16 = 1'b0;
    for (int k = 1; k <= W16 + 8; k++) begin
      @(negedge clk);
      if (done16) break;
    end
  endtask

  // Stimulus: directed cases, mid-op reset, then randomized traffic on both widths.
  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    start = 1'b0; ALUOperation = 4'd0; A = '0; B = '0; Shamt = '0;
    start16 = 1'b0; op16 = 4'd0; a16 = 16'd0; b16 = 16'd0; sh16 = 4'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    issue(OP_BEQ, 32'h0000_1234, 32'h0000_1234, 5'd0, 0);
    issue(OP_SLL, 32'h0000_0000, 32'h0000_0001, 5'd31, 0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd0, 0);
    issue(OP_DIVU, 32'd5, 32'd0, 5'd0, 0);
    issue(OP_MULTU, 32'h0001_2345, 32'h0000_6789, 5'd0, 1);
    issue(OP_MEM, 32'h1001_0008, 32'h0000_0004, 5'd0, 0);
    issue(OP_LUI, 32'h0, 32'hABCD_1234, 5'd0, 0);
    issue(OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 0);

    ALUOperation = OP_DIVU; A = $urandom; B = 32'($urandom_range(1, 1000)); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (W + 6) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 1) ? OP_MULTU : OP_DIVU)
                                       : 4'($urandom_range(0, 15));
      ra = pick(); rb = pick();
      if (op == OP_DIVU && $urandom_range(0, 3) == 0) rb = 32'd0;
      issue(op, ra, rb, 5'($urandom), 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    issue16(OP_MULTU, 16'hFFFF, 16'h0002, 4'd0);
    for (int i = 0; i < 20; i++) begin
      op = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 1) ? OP_MULTU : OP_DIVU)
                                       : 4'($urandom_range(0, 15));
      ra = pick(); rb = pick();
      if (op == OP_DIVU && $urandom_range(0, 3) == 0) rb = 32'd0;
      issue16(op, ra[15:0], rb[15:0], 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    end_req = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary within the time limit");
    $fatal(1);
  end

endmodule
